// File: rtl/cam_capture_writer_if.sv
// Camera capture bus: DVP input side, FIFO write side and status flags.
// master drives the camera bus and FIFO-full flag; slave is the capture block.
interface cam_capture_writer_if;
   logic        start;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        full_fifo;
   logic        wr_en;
   logic [15:0] dout;
   logic        frame_done;
   logic        overflow;
   logic        busy;

   modport master (
      output start, cam_vsync, cam_href, cam_data, full_fifo,
      input  wr_en, dout, frame_done, overflow, busy
   );

   modport slave (
      input  start, cam_vsync, cam_href, cam_data, full_fifo,
      output wr_en, dout, frame_done, overflow, busy
   );
endinterface

// File: rtl/cam_capture_writer.sv
// Camera-side write end of the async pixel FIFO. Assembles DVP byte pairs
// into RGB565 pixels, skips the sensor's settling frames after start, clips
// to the H_PIXELS x V_LINES window and flags pixels lost to a full FIFO.
module cam_capture_writer #(
   parameter int SKIP_FRAMES = 2,
   parameter int H_PIXELS    = 640,
   parameter int V_LINES     = 480
) (
   input logic                 clk,
   input logic                 rst_n,
   cam_capture_writer_if.slave bus
);

   // Counter widths: pixel_x / pixel_y saturate at the window size, so they
   // need one code beyond the last in-window index.
   localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
   localparam int XW  = (H_PIXELS > 0) ? $clog2(H_PIXELS + 1) : 1;
   localparam int YW  = (V_LINES > 0) ? $clog2(V_LINES + 1) : 1;

   localparam logic [XW-1:0]  X_MAX     = XW'(H_PIXELS);
   localparam logic [YW-1:0]  Y_MAX     = YW'(V_LINES);
   localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

   typedef enum logic [1:0] {
      WAIT_START = 2'd0,
      SKIP       = 2'd1,
      WAIT_FRAME = 2'd2,
      CAPTURE    = 2'd3
   } state_t;

   state_t          state_q,      state_d;
   logic [SKW-1:0]  skip_cnt_q,   skip_cnt_d;
   logic            byte_phase_q, byte_phase_d;
   logic [XW-1:0]   pixel_x_q,    pixel_x_d;
   logic [YW-1:0]   pixel_y_q,    pixel_y_d;
   logic [7:0]      hi_q,         hi_d;
   logic            wr_en_q,      wr_en_d;
   logic [15:0]     dout_q,       dout_d;
   logic            frame_done_q, frame_done_d;
   logic            overflow_q,   overflow_d;
   logic            vsync_q;
   logic            href_q;

   logic            vs_rise;
   logic            vs_fall;
   logic            href_fall;
   logic            in_window;
   logic [15:0]     pixel;

   assign vs_rise   = bus.cam_vsync & ~vsync_q;
   assign vs_fall   = ~bus.cam_vsync & vsync_q;
   assign href_fall = ~bus.cam_href & href_q;

   // The high byte arrives first on the bus.
   assign pixel     = {hi_q, bus.cam_data};
   assign in_window = (pixel_x_q < X_MAX) && (pixel_y_q < Y_MAX);

   // State, counters, output registers and sync-edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_START;
         skip_cnt_q   <= '0;
         byte_phase_q <= 1'b0;
         pixel_x_q    <= '0;
         pixel_y_q    <= '0;
         hi_q         <= '0;
         wr_en_q      <= 1'b0;
         dout_q       <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         skip_cnt_q   <= skip_cnt_d;
         byte_phase_q <= byte_phase_d;
         pixel_x_q    <= pixel_x_d;
         pixel_y_q    <= pixel_y_d;
         hi_q         <= hi_d;
         wr_en_q      <= wr_en_d;
         dout_q       <= dout_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         vsync_q      <= bus.cam_vsync;
         href_q       <= bus.cam_href;
      end
   end

   // Next-state logic: frame sequencing, byte pairing, clipping and FIFO writes.
   always_comb begin
      state_d      = state_q;
      skip_cnt_d   = skip_cnt_q;
      byte_phase_d = byte_phase_q;
      pixel_x_d    = pixel_x_q;
      pixel_y_d    = pixel_y_q;
      hi_d         = hi_q;
      wr_en_d      = 1'b0;
      dout_d       = dout_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;

      case (state_q)
         WAIT_START: begin
            if (bus.start) begin
               skip_cnt_d = '0;
               overflow_d = 1'b0;
               state_d    = (SKIP_FRAMES == 0) ? WAIT_FRAME : SKIP;
            end
         end

         SKIP: begin
            // Each vsync rise closes one settling frame.
            if (vs_rise) begin
               skip_cnt_d = skip_cnt_q + 1'b1;
               if (skip_cnt_q == SKIP_LAST) begin
                  state_d = WAIT_FRAME;
               end
            end
         end

         WAIT_FRAME: begin
            // vsync falling marks the start of active lines.
            if (vs_fall) begin
               pixel_x_d    = '0;
               pixel_y_d    = '0;
               byte_phase_d = 1'b0;
               state_d      = CAPTURE;
            end
         end

         CAPTURE: begin
            if (vs_rise) begin
               // start is only re-examined at frame boundaries, so a frame in
               // progress always completes.
               frame_done_d = 1'b1;
               state_d      = bus.start ? WAIT_FRAME : WAIT_START;
            end else if (href_fall) begin
               // A dangling odd byte at line end is dropped with the phase.
               pixel_x_d    = '0;
               byte_phase_d = 1'b0;
               if (pixel_y_q != Y_MAX) begin
                  pixel_y_d = pixel_y_q + 1'b1;
               end
            end else if (bus.cam_href) begin
               if (!byte_phase_q) begin
                  hi_d         = bus.cam_data;
                  byte_phase_d = 1'b1;
               end else begin
                  byte_phase_d = 1'b0;
                  // Counters advance even for dropped or clipped pixels so
                  // the frame geometry stays aligned.
                  if (pixel_x_q != X_MAX) begin
                     pixel_x_d = pixel_x_q + 1'b1;
                  end
                  if (in_window) begin
                     if (bus.full_fifo) begin
                        overflow_d = 1'b1;
                     end else begin
                        wr_en_d = 1'b1;
                        dout_d  = pixel;
                     end
                  end
               end
            end
         end

         default: begin
            state_d = WAIT_START;
         end
      endcase
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.dout       = dout_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.busy       = (state_q == CAPTURE);

endmodule

// File: tb/tb_cam_capture_writer.sv
// Testbench for cam_capture_writer: randomized DVP frames checked against a
// frame-level reference model (which frames are captured, which pixels land
// in the FIFO, overflow and frame_done expectations).
module tb_cam_capture_writer;

   localparam int SKIP = 2;
   localparam int HP   = 4;
   localparam int VL   = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   cam_capture_writer_if bus ();

   cam_capture_writer #(
      .SKIP_FRAMES(SKIP),
      .H_PIXELS   (HP),
      .V_LINES    (VL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] act_q[$];
   logic [15:0] exp_q[$];
   int          fd_cnt     = 0;
   int          consec_err = 0;
   logic        wr_prev    = 1'b0;

   // Reference model state: idle (not started), vsync rises since start,
   // expected sticky overflow.
   bit m_idle  = 1'b1;
   int m_rises = 0;
   bit m_ovf   = 1'b0;

   // Write/frame_done monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         act_q.push_back(bus.dout);
         if (wr_prev) consec_err++;
      end
      wr_prev = (bus.wr_en === 1'b1);
      if (bus.frame_done === 1'b1) fd_cnt++;
   end

   function automatic bit m_captured();
      return !m_idle && (m_rises >= SKIP);
   endfunction

   task automatic drive(input logic vs, input logic hr, input logic [7:0] d, input logic full);
      bus.cam_vsync = vs;
      bus.cam_href  = hr;
      bus.cam_data  = d;
      bus.full_fifo = full;
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      if (v && m_idle) begin
         m_idle  = 1'b0;
         m_rises = 0;
         m_ovf   = 1'b0;
      end
      bus.start = v;
   endtask

   task automatic vsync_pulse(input bit cap, input string tag);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.frame_done !== cap) begin
         errors++;
         $display("FAIL %s frame_done_pulse: got %b want %b", tag, bus.frame_done, cap);
      end
      repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
      if (!m_idle) begin
         m_rises++;
         if (cap && !bus.start) m_idle = 1'b1;
      end
      repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_frame(input int nlines, input int nbytes, input int full_line,
                             input int full_pix, input int drop_line, input string tag);
      logic [7:0] bytes[64];
      logic [7:0] d;
      logic       full;
      bit         cap;
      int         bad;
      cap = m_captured();
      act_q.delete();
      exp_q.delete();
      fd_cnt     = 0;
      consec_err = 0;
      for (int l = 0; l < nlines; l++) begin
         if (l == drop_line) bus.start = 1'b0;
         for (int b = 0; b < nbytes; b++) begin
            d        = 8'($urandom);
            full     = (l == full_line) && ((b / 2) == full_pix);
            bytes[b] = d;
            drive(1'b0, 1'b1, d, full);
            if (l == 0 && b == 0) begin
               checks++;
               if (bus.busy !== cap) begin
                  errors++;
                  $display("FAIL %s busy: got %b want %b", tag, bus.busy, cap);
               end
            end
         end
         for (int p = 0; p < nbytes / 2; p++) begin
            if (cap && l < VL && p < HP) begin
               if (l == full_line && p == full_pix) m_ovf = 1'b1;
               else exp_q.push_back({bytes[2*p], bytes[2*p+1]});
            end
         end
         repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
      end
      vsync_pulse(cap, tag);

      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s write_count: got %0d want %0d", tag, act_q.size(), exp_q.size());
      end
      bad = -1;
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         if (act_q[i] !== exp_q[i] && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s pixel[%0d]: got %h want %h", tag, bad, act_q[bad], exp_q[bad]);
      end
      checks++;
      if (fd_cnt != (cap ? 1 : 0)) begin
         errors++;
         $display("FAIL %s frame_done_count: got %0d want %0d", tag, fd_cnt, cap ? 1 : 0);
      end
      checks++;
      if (bus.overflow !== m_ovf) begin
         errors++;
         $display("FAIL %s overflow: got %b want %b", tag, bus.overflow, m_ovf);
      end
      checks++;
      if (consec_err != 0) begin
         errors++;
         $display("FAIL %s wr_en_back_to_back: got %0d want 0", tag, consec_err);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({bus.wr_en, bus.dout, bus.frame_done, bus.overflow, bus.busy} !== 20'h0) begin
         errors++;
         $display("FAIL %s outputs: got wr_en=%b dout=%h fd=%b ovf=%b busy=%b want all 0",
                  tag, bus.wr_en, bus.dout, bus.frame_done, bus.overflow, bus.busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_held");
      rst_n  = 1'b1;
      m_idle = 1'b1;
      repeat (3) drive(1'b0, 1'b1, 8'hAA, 1'b0);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      check_all_zero("idle_no_start");
   endtask

   task automatic test_skip();
      set_start(1'b1);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      send_frame(4, 8, -1, -1, -1, "skip_f1");
      send_frame(4, 8, -1, -1, -1, "skip_f2");
      send_frame(4, 8, -1, -1, -1, "skip_f3");
   endtask

   task automatic test_byte_order();
      act_q.delete();
      drive(1'b0, 1'b1, 8'hF8, 1'b0);
      checks++;
      if (bus.wr_en !== 1'b0) begin
         errors++;
         $display("FAIL byte_order early_wr_en: got %b want 0", bus.wr_en);
      end
      drive(1'b0, 1'b1, 8'h1F, 1'b0);
      checks++;
      if (bus.wr_en !== 1'b1) begin
         errors++;
         $display("FAIL byte_order wr_en: got %b want 1", bus.wr_en);
      end
      checks++;
      if (bus.dout !== 16'hF81F) begin
         errors++;
         $display("FAIL byte_order dout: got %h want f81f", bus.dout);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.wr_en !== 1'b0 || bus.dout !== 16'hF81F) begin
         errors++;
         $display("FAIL byte_order hold: got wr_en=%b dout=%h want 0 f81f", bus.wr_en, bus.dout);
      end
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      vsync_pulse(m_captured(), "byte_order");
      checks++;
      if (act_q.size() != 1) begin
         errors++;
         $display("FAIL byte_order write_count: got %0d want 1", act_q.size());
      end
   endtask

   task automatic test_clipping();
      send_frame(5, 11, -1, -1, -1, "clip");
   endtask

   task automatic test_overflow();
      send_frame(4, 8, 1, 1, -1, "ovf_hit");
      send_frame(4, 8, -1, -1, -1, "ovf_sticky");
   endtask

   task automatic test_start_drop();
      send_frame(4, 8, -1, -1, 2, "drop_frame");
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL start_drop busy_after: got %b want 0", bus.busy);
      end
      send_frame(4, 8, -1, -1, -1, "drop_idle");
      set_start(1'b1);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.overflow !== m_ovf) begin
         errors++;
         $display("FAIL restart overflow_clear: got %b want %b", bus.overflow, m_ovf);
      end
   endtask

   task automatic test_async_reset();
      send_frame(4, 8, -1, -1, -1, "pre_rst_f1");
      send_frame(4, 8, -1, -1, -1, "pre_rst_f2");
      act_q.delete();
      drive(1'b0, 1'b1, 8'hA5, 1'b0);
      drive(1'b0, 1'b1, 8'h5A, 1'b0);
      checks++;
      if (bus.wr_en !== 1'b1 || bus.dout !== 16'hA55A) begin
         errors++;
         $display("FAIL pre_reset write: got wr_en=%b dout=%h want 1 a55a", bus.wr_en, bus.dout);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (3) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
      rst_n   = 1'b1;
      m_idle  = 1'b0;
      m_rises = 0;
      m_ovf   = 1'b0;
      repeat (3) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset partial_write: got %0d want 0", act_q.size());
      end
      send_frame(4, 8, -1, -1, -1, "cold_f1");
      send_frame(4, 8, -1, -1, -1, "cold_f2");
      send_frame(4, 8, -1, -1, -1, "cold_f3");
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.cam_vsync = 1'b0;
      bus.cam_href  = 1'b0;
      bus.cam_data  = 8'h00;
      bus.full_fifo = 1'b0;
      test_reset();
      test_skip();
      test_byte_order();
      test_clipping();
      test_overflow();
      test_start_drop();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
